// File: rtl/mul_share_arbiter.sv
// Shares one pipelined FP16 multiplier between two requesters.
// Issue is round-robin and gated by per-requester credits. Results return
// through per-requester FIFOs, in issue order for each requester.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   reqN_valid/reqN_ready/reqN_a/b    operand issue handshake, N = 0,1
//   rspN_valid/rspN_ready/rspN_result result return handshake, N = 0,1
//   busy                              an op is in the pipe or a FIFO holds data
module mul_share_arbiter #(
   parameter int unsigned LAT        = 2,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_a,
   input  logic [15:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_a,
   input  logic [15:0] req1_b,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [15:0] rsp0_result,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [15:0] rsp1_result,
   output logic        busy
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   // Truncating FP16 multiply; exponent field 0 still carries the hidden 1.
   function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
      logic        s;
      logic [4:0]  e;
      logic [21:0] p;
      s = a[15] ^ b[15];
      e = a[14:10] + b[14:10] - 5'd15;
      p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
      fp16_mul = p[21] ? {s, e + 5'd1, p[20:11]} : {s, e, p[19:10]};
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      next_ptr = (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   logic [CW-1:0] cred      [2];
   logic [CW-1:0] count     [2];
   logic [PW-1:0] wptr      [2];
   logic [PW-1:0] rptr      [2];
   logic [15:0]   fifo_mem  [2][FIFO_DEPTH];
   logic [15:0]   pipe_data [LAT];
   logic [LAT-1:0] pipe_valid;
   logic [LAT-1:0] pipe_tag;
   logic          rr_last;
   logic          cand0, cand1;
   logic [1:0]    grant;
   logic [1:0]    wr_en;
   logic [1:0]    pop;
   logic [1:0]    rsp_rdy;

   assign cand0   = req0_valid & (cred[0] < CW'(FIFO_DEPTH));
   assign cand1   = req1_valid & (cred[1] < CW'(FIFO_DEPTH));
   assign rsp_rdy = {rsp1_ready, rsp0_ready};

   // Round-robin pick: on a tie the requester not granted last time wins.
   always_comb begin
      grant = 2'b00;
      if (cand0 && cand1) begin
         grant[0] = rr_last;
         grant[1] = ~rr_last;
      end else begin
         grant[0] = cand0;
         grant[1] = cand1;
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // FIFO write from the last pipe stage, pop on the response handshake.
   always_comb begin
      wr_en = 2'b00;
      pop   = 2'b00;
      for (int r = 0; r < 2; r++) begin
         wr_en[r] = pipe_valid[LAT-1] & (pipe_tag[LAT-1] == 1'(r));
         pop[r]   = (count[r] != '0) & rsp_rdy[r];
      end
   end

   // Pipe control: valid and requester tag shift along with the data.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_valid <= '0;
         pipe_tag   <= '0;
      end else begin
         pipe_valid[0] <= |grant;
         pipe_tag[0]   <= grant[1];
         for (int unsigned k = 1; k < LAT; k++) begin
            pipe_valid[k] <= pipe_valid[k-1];
            pipe_tag[k]   <= pipe_tag[k-1];
         end
      end
   end

   // Pipe data: product formed at issue, then delayed to the FIFO write point.
   always_ff @(posedge clk) begin
      pipe_data[0] <= grant[1] ? fp16_mul(req1_a, req1_b) : fp16_mul(req0_a, req0_b);
      for (int unsigned k = 1; k < LAT; k++) begin
         pipe_data[k] <= pipe_data[k-1];
      end
   end

   // Arbiter history, FIFO pointers/occupancy and credits.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last <= 1'b1;
         for (int r = 0; r < 2; r++) begin
            wptr[r]  <= '0;
            rptr[r]  <= '0;
            count[r] <= '0;
            cred[r]  <= '0;
         end
      end else begin
         if (|grant) begin
            rr_last <= grant[1];
         end
         for (int r = 0; r < 2; r++) begin
            if (wr_en[r]) begin
               wptr[r] <= next_ptr(wptr[r]);
            end
            if (pop[r]) begin
               rptr[r] <= next_ptr(rptr[r]);
            end
            count[r] <= count[r] + CW'(wr_en[r]) - CW'(pop[r]);
            cred[r]  <= cred[r] + CW'(grant[r]) - CW'(pop[r]);
         end
      end
   end

   // FIFO storage needs no reset; the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      for (int r = 0; r < 2; r++) begin
         if (wr_en[r]) begin
            fifo_mem[r][wptr[r]] <= pipe_data[LAT-1];
         end
      end
   end

   assign rsp0_valid  = (count[0] != '0);
   assign rsp1_valid  = (count[1] != '0);
   assign rsp0_result = rsp0_valid ? fifo_mem[0][rptr[0]] : '0;
   assign rsp1_result = rsp1_valid ? fifo_mem[1][rptr[1]] : '0;
   assign busy        = (|pipe_valid) | rsp0_valid | rsp1_valid;

endmodule
